// File: rtl/sap_ram_pkg.sv
// Shared definitions for sap_sync_ram: the clear-sequencer state encoding and the
// even-parity helper used when RAM_PARITY_EN is defined.
package sap_ram_pkg;

  typedef enum logic {
    CLEARING = 1'b0,
    READY    = 1'b1
  } ram_state_t;

  // Widest data word the parity helper covers; callers zero-extend into it.
  localparam int PARITY_MAX_W = 64;

  function automatic logic evenParity(input logic [PARITY_MAX_W-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/sap_ram_clear_seq.sv
// Post-reset clear sequencer for sap_sync_ram: walks every word address once,
// requesting a zero write per edge, then parks in READY until the next reset.
module sap_ram_clear_seq
  import sap_ram_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              i_clk,
  input  logic              i_clr,
  output logic              o_busy,
  output logic [ADDR_W-1:0] o_clearAddr,
  output logic              o_clearWe
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  ram_state_t        r_state;
  ram_state_t        w_nextState;
  logic [ADDR_W-1:0] r_clearCount;
  logic [ADDR_W-1:0] w_nextCount;

  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state      <= CLEARING;
      r_clearCount <= '0;
    end else begin
      r_state      <= w_nextState;
      r_clearCount <= w_nextCount;
    end
  end

  // The array must not be touched while reset is held, so the strobe is gated by i_clr.
  always_comb begin
    w_nextState = r_state;
    w_nextCount = r_clearCount;
    o_clearWe   = 1'b0;
    case (r_state)
      CLEARING: begin
        o_clearWe = !i_clr;
        if (r_clearCount == LAST_ADDR) begin
          w_nextState = READY;
          w_nextCount = '0;
        end else begin
          w_nextCount = r_clearCount + 1'b1;
        end
      end
      READY:   ;
      default: w_nextState = CLEARING;
    endcase
  end

  assign o_busy      = (r_state == CLEARING);
  assign o_clearAddr = r_clearCount;

endmodule

// File: rtl/sap_sync_ram.sv
// Synchronous WIDTH x DEPTH scratchpad with registered read, valid strobe and
// self-clear after reset. Define RAM_PARITY_EN to store and check even parity per word.
module sap_sync_ram
  import sap_ram_pkg::*;
#(
  parameter int    WIDTH  = 8,
  parameter int    DEPTH  = 16,
  localparam int   ADDR_W = $clog2(DEPTH)
) (
  input  logic              CLK,
  input  logic              CLR,
  input  logic [ADDR_W-1:0] A,
  input  logic [WIDTH-1:0]  DI,
  input  logic              S_bar,
  input  logic              W_bar,
  output logic [WIDTH-1:0]  DO,
  output logic              DO_VALID,
  output logic              BUSY,
  output logic              PERR
);

`ifdef RAM_PARITY_EN
  localparam int STORE_W = WIDTH + 1;
`else
  localparam int STORE_W = WIDTH;
`endif

  logic [STORE_W-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0]   r_do;
  logic               r_doValid;

  logic               w_busy;
  logic               w_clearWe;
  logic [ADDR_W-1:0]  w_clearAddr;
  logic               w_inRange;
  logic               w_userWe;
  logic               w_userRd;
  logic               w_memWe;
  logic [ADDR_W-1:0]  w_memAddr;
  logic [STORE_W-1:0] w_memWdata;
  logic [STORE_W-1:0] w_rdWord;

  sap_ram_clear_seq #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_clearSeq (
    .i_clk      (CLK),
    .i_clr      (CLR),
    .o_busy     (w_busy),
    .o_clearAddr(w_clearAddr),
    .o_clearWe  (w_clearWe)
  );

  // Only non-power-of-two depths can present an address past the last word.
  assign w_inRange = ({1'b0, A} < (ADDR_W + 1)'(DEPTH));
  assign w_userWe  = !w_busy && !CLR && !S_bar && !W_bar && w_inRange;
  assign w_userRd  = !w_busy && !S_bar && W_bar;
  assign w_memWe   = w_clearWe || w_userWe;
  assign w_memAddr = w_busy ? w_clearAddr : A;

`ifdef RAM_PARITY_EN
  assign w_memWdata = w_busy ? '0 : {evenParity(PARITY_MAX_W'(DI)), DI};
`else
  assign w_memWdata = w_busy ? '0 : DI;
`endif

  always_ff @(posedge CLK) begin
    if (w_memWe) begin
      r_mem[w_memAddr] <= w_memWdata;
    end
  end

  assign w_rdWord = r_mem[A];

  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_do      <= '0;
      r_doValid <= 1'b0;
    end else begin
      r_doValid <= w_userRd;
      if (w_userRd) begin
        r_do <= w_inRange ? w_rdWord[WIDTH-1:0] : '0;
      end
    end
  end

`ifdef RAM_PARITY_EN
  logic r_perr;

  // PERR only reports alongside a valid in-range read and is 0 otherwise.
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_perr <= 1'b0;
    end else begin
      r_perr <= w_userRd && w_inRange &&
                (w_rdWord[WIDTH] != evenParity(PARITY_MAX_W'(w_rdWord[WIDTH-1:0])));
    end
  end

  assign PERR = r_perr;
`else
  assign PERR = 1'b0;
`endif

  assign DO       = r_do;
  assign DO_VALID = r_doValid;
  assign BUSY     = w_busy;

endmodule

// File: tb/tb_sap_sync_ram.sv
// Self-checking bench for sap_sync_ram: a 16-word and a 12-word instance (WIDTH=4)
// exercised through a vector table plus hand-written clear/reset sequences.
module tb_sap_sync_ram;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr16, sb16, wb16, v16, busy16, perr16;
  logic [3:0] a16, di16, do16;
  logic       clr12, sb12, wb12, v12, busy12, perr12;
  logic [3:0] a12, di12, do12;

  sap_sync_ram #(.WIDTH(4), .DEPTH(16)) dut16 (
    .CLK(clk), .CLR(clr16), .A(a16), .DI(di16), .S_bar(sb16), .W_bar(wb16),
    .DO(do16), .DO_VALID(v16), .BUSY(busy16), .PERR(perr16)
  );

  sap_sync_ram #(.WIDTH(4), .DEPTH(12)) dut12 (
    .CLK(clk), .CLR(clr12), .A(a12), .DI(di12), .S_bar(sb12), .W_bar(wb12),
    .DO(do12), .DO_VALID(v12), .BUSY(busy12), .PERR(perr12)
  );

  typedef struct {
    logic       which;
    logic [3:0] expDo;
    logic       expValid;
    logic       expPerr;
  } sbEntry_t;

  typedef struct {
    logic       wr;
    logic       sel;
    logic [3:0] addr;
    logic [3:0] data;
    logic [3:0] expDo;
    logic       expValid;
  } vec_t;

  sbEntry_t sbq[$];
  vec_t     vecs[$];
  int       checks   = 0;
  int       failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic which, input logic clr, input logic sb,
                               input logic wb, input logic [3:0] a, input logic [3:0] di,
                               input logic [3:0] expDo, input logic expValid,
                               input logic expPerr);
    sbEntry_t e;
    if (!which) begin
      clr16 = clr; sb16 = sb; wb16 = wb; a16 = a; di16 = di;
    end else begin
      clr12 = clr; sb12 = sb; wb12 = wb; a12 = a; di12 = di;
    end
    e.which = which; e.expDo = expDo; e.expValid = expValid; e.expPerr = expPerr;
    sbq.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    sbEntry_t e;
    tick();
    e = sbq.pop_front();
    if (!e.which) begin
      check({name, ".do"},    int'(do16),   int'(e.expDo));
      check({name, ".valid"}, int'(v16),    int'(e.expValid));
      check({name, ".perr"},  int'(perr16), int'(e.expPerr));
    end else begin
      check({name, ".do"},    int'(do12),   int'(e.expDo));
      check({name, ".valid"}, int'(v12),    int'(e.expValid));
      check({name, ".perr"},  int'(perr12), int'(e.expPerr));
    end
  endtask

  task automatic waitClear(input logic which, input int expEdges, input string name);
    int   n = 0;
    logic b;
    do begin
      tick();
      n++;
      b = which ? busy12 : busy16;
    end while (b && n < 64);
    check(name, n, expEdges);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         n;
    logic [3:0] lastDo;
    logic [3:0] ra;

    clr16 = 1'b1; sb16 = 1'b1; wb16 = 1'b1; a16 = '0; di16 = '0;
    clr12 = 1'b1; sb12 = 1'b1; wb12 = 1'b1; a12 = '0; di12 = '0;

    // Reset held three cycles, then clear with a write injected at clear cycle 5.
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      checkOutput("reset16");
      check("reset16.busy", int'(busy16), 1);
    end
    clr16 = 1'b0;
    n = 0;
    do begin
      n++;
      sb16 = (n == 5) ? 1'b0 : 1'b1;
      wb16 = (n == 5) ? 1'b0 : 1'b1;
      a16  = 4'h3;
      di16 = 4'hA;
      tick();
      if (n == 5) check("busyWrite.valid", int'(v16), 0);
    end while (busy16 && n < 64);
    check("clear16.len", n, 16);

    for (int k = 0; k < 16; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'(k), 4'h0, 4'h0, 1'b1, 1'b0);
      checkOutput($sformatf("zeroRead%0d", k));
    end

    // Vector table: fill, random readback with idle gaps, write-then-read same address.
    lastDo = 4'h0;
    for (int k = 0; k < 16; k++)
      vecs.push_back('{1'b1, 1'b1, 4'(k), 4'((k + 5) % 16), lastDo, 1'b0});
    for (int i = 0; i < 20; i++) begin
      ra = 4'($urandom_range(0, 15));
      lastDo = ra + 4'd5;
      vecs.push_back('{1'b0, 1'b1, ra, 4'h0, lastDo, 1'b1});
      vecs.push_back('{1'b0, 1'b0, ra, 4'h0, lastDo, 1'b0});
    end
    vecs.push_back('{1'b1, 1'b1, 4'h7, 4'h9, lastDo, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 4'h7, 4'h0, 4'h9, 1'b1});
    foreach (vecs[i]) begin
      applyStimulus(1'b0, 1'b0, !vecs[i].sel, !vecs[i].wr, vecs[i].addr, vecs[i].data,
                    vecs[i].expDo, vecs[i].expValid, 1'b0);
      checkOutput($sformatf("vec%0d", i));
    end

    // Reset during an access aborts it; a second reset mid-clear restarts the walk.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h2, 4'h7, 4'h9, 1'b0, 1'b0);
    checkOutput("wr2");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h0, 4'h7, 1'b1, 1'b0);
    checkOutput("rd2");
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("abort");
    check("abort.busy", int'(busy16), 1);
    clr16 = 1'b0; sb16 = 1'b1; wb16 = 1'b1;
    repeat (7) tick();
    clr16 = 1'b1;
    tick();
    check("midClear.busy", int'(busy16), 1);
    clr16 = 1'b0;
    waitClear(1'b0, 16, "clear16.restart");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("postClr.rd2");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'hF, 4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("postClr.rd15");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h7, 4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("postClr.rd7");

`ifdef RAM_PARITY_EN
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'h4, 4'h5, 4'h0, 1'b0, 1'b0);
    checkOutput("par.wr4");
    dut16.r_mem[4][0] = ~dut16.r_mem[4][0];
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h4, 4'h0, 4'h4, 1'b1, 1'b1);
    checkOutput("par.rd4");
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h2, 4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("par.rd2");
`endif

    // Twelve-word instance: out-of-range accesses past the last word.
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    checkOutput("reset12");
    clr12 = 1'b0;
    waitClear(1'b1, 12, "clear12.len");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'(k), 4'((k + 9) % 16), 4'h0, 1'b0, 1'b0);
      checkOutput($sformatf("d12.wr%0d", k));
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'hD, 4'hF, 4'h0, 1'b0, 1'b0);
    checkOutput("d12.wrOob");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'h5, 4'h0, 4'hE, 1'b1, 1'b0);
    checkOutput("d12.rd5");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'hD, 4'h0, 4'h0, 1'b1, 1'b0);
    checkOutput("d12.rdOob");
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'(k), 4'h0, 4'((k + 9) % 16), 1'b1, 1'b0);
      checkOutput($sformatf("d12.rd%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sap_sync_ram.md
# sap_sync_ram

Parametrised, fully synchronous read/write memory, the clocked successor to the 16x4 asynchronous scratchpad in the 7400 library. It provides WIDTH x DEPTH storage with a registered read port and a valid strobe. After every reset it zeroes its own contents with a hardware clear sequencer. It sits between the SAP address register (MAR) and the W bus. It never drives high-Z; bus isolation belongs to the bus-mux block.

## Interface
- WIDTH, 8: data word width in bits, at least 1.
- DEPTH, 16: number of words, at least 2, not necessarily a power of two.
- ADDR_W, $clog2(DEPTH): address width, derived; not for override.

- CLK  in  1  single clock; all state updates on the rising edge.
- CLR  in  1  reset, synchronous, active-high.
- A  in  ADDR_W  word address.
- DI  in  WIDTH  write data.
- S_bar  in  1  chip select, active-low.
- W_bar  in  1  write enable, active-low; 1 selects a read.
- DO  out  WIDTH  registered read data, true polarity (not inverted).
- DO_VALID  out  1  one-cycle strobe, DO updated this cycle.
- BUSY  out  1  clear sequence in progress; all accesses ignored.
- PERR  out  1  parity error on the word in DO; constant 0 unless RAM_PARITY_EN is defined.

## Operation
- Reset (CLR=1 at an edge):
  - DO=0, DO_VALID=0, PERR=0, BUSY=1.
  - Clear counter = 0; state = CLEARING.
  - Memory contents are not touched while CLR is held.
- CLEARING:
  - Each edge with CLR=0 writes 0 (and correct parity) to word[counter], then increments the counter.
  - After writing word DEPTH-1, the next state is READY and BUSY drops.
- READY:
  - Write: S_bar=0, W_bar=0, A<DEPTH. word[A] is set to DI at the edge. DO is unchanged and DO_VALID=0.
  - Read: S_bar=0, W_bar=1. At the edge DO is set to word[A] and DO_VALID=1 for that one cycle.
  - Idle: S_bar=1. DO holds its last value and DO_VALID=0.
- Out-of-range A (A>=DEPTH, possible only for non-power-of-two DEPTH):
  - A write is dropped.
  - A read returns DO=0, PERR=0, DO_VALID=1.
- Accesses presented while BUSY=1 are dropped silently, with no DO_VALID.
- CLR asserted mid-clear restarts the sequence from word 0.
- CLR asserted mid-operation aborts any pending access and re-clears the whole array.
- Read and write cannot coincide: W_bar selects exactly one. A read of an address written on the previous edge returns the new data.

## Timing
- Read latency: 1 cycle. A, S_bar and W_bar are sampled at edge n; DO and DO_VALID are valid after edge n.
- Write latency: 1 cycle; the data is visible to a read sampled at the next edge.
- Clear duration: exactly DEPTH edges after the first edge with CLR=0. BUSY is low from edge DEPTH onward.
- Throughput: one access per cycle in READY. There are no wait states.
- Every output is driven from a flop; there are no combinational paths from inputs to outputs.

## Configuration
- RAM_PARITY_EN defined:
  - Each word stores an extra even-parity bit computed from DI at write time, and from zero data during clear.
  - On a read, PERR is registered alongside DO: PERR=1 if the stored parity disagrees with the stored data.
  - PERR is valid only when DO_VALID=1; otherwise it is 0.
- RAM_PARITY_EN undefined:
  - Storage is WIDTH bits per word.
  - PERR is tied to 0.
  - Behaviour is otherwise identical.

## Structure
- Package sap_ram_pkg holds:
  - the state enum {CLEARING, READY};
  - the parity function.
- Sub-module sap_ram_clear_seq holds:
  - the clear counter and state;
  - outputs BUSY, clear address and clear write strobe.
- The top level muxes the clear-write path against the user-write path onto the single array write port.

## Test plan
- Reset then clear (DEPTH=16, WIDTH=4):
  - Hold CLR 3 cycles, then release. BUSY must stay 1 for exactly 16 edges.
  - Then read all 16 addresses: every DO=0 with DO_VALID=1.
- Fill and readback:
  - Write (k+5)%16 to address k for k=0..15.
  - Read 20 random addresses: DO=(A+5)%16, 1-cycle latency, DO_VALID a single-cycle pulse.
- Access during BUSY: a write of 4'hA to address 3 issued at clear cycle 5 is dropped; a later read of address 3 returns 0.
- CLR mid-clear and mid-operation:
  - Write 4'h7 to address 2.
  - Assert CLR mid-clear at cycle 8, then release. BUSY must last 16 more edges.
  - A read of address 2 then returns 0.
- Non-power-of-two DEPTH=12:
  - A write to A=13 is ignored.
  - A read of A=13 gives DO=0 with DO_VALID=1.
  - Words 0..11 are unaffected.
- With RAM_PARITY_EN:
  - Write 4'h5 to address 4, then force-flip stored data bit 0.
  - A read of address 4 gives DO=4'h4 and PERR=1.
  - A read of an uncorrupted address gives PERR=0.
